serial_receiver_frame: RTL

//  Parametrised successor of the fixed 8N1 byte receiver. Samples one serial bit per clk.

---
 rtl/serial_receiver_frame.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_receiver_frame.sv
// Configurable serial frame receiver: start bit, DATA_BITS data bits LSB first, optional parity,
// 1..2 stop bits. Good frames land in a valid/ready output register; errors pulse a flag.
module serial_receiver_frame #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 done,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int               CNT_W     = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic             ODD       = (PARITY_ODD != 0);
   localparam logic             HAS_PAR   = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_ERR_WAIT
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       r_count;
   logic                   r_stop_idx;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_par;
   logic [DATA_BITS-1:0]   r_out_data;
   logic                   r_out_valid;
   logic                   r_done;
   logic                   r_perr;
   logic                   r_ferr;
   logic                   r_ovr;

   logic                   w_shift_en;
   logic                   w_par_ld;
   logic                   w_commit;
   logic                   w_stop_bad;
   logic                   w_par_ok;
   logic                   w_load;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_par_ld    = 1'b0;
      w_commit    = 1'b0;
      w_stop_bad  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!in) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_shift_en = 1'b1;
            if (r_count == LAST_CNT) begin
               if (HAS_PAR) w_state_nxt = S_PARITY;
               else         w_state_nxt = S_STOP;
            end
         end
         S_PARITY: begin
            w_par_ld    = 1'b1;
            w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (!in) begin
               w_stop_bad  = 1'b1;
               w_state_nxt = S_ERR_WAIT;
            end else if (r_stop_idx == LAST_STOP) begin
               w_commit    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR_WAIT: begin
            // Line must return high before a new start bit can be recognised
            if (in) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_par_ok = !HAS_PAR || (r_par == ((^r_shift) ^ ODD));
   assign w_load   = w_commit && w_par_ok && (!r_out_valid || out_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count     <= '0;
         r_stop_idx  <= 1'b0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_count    <= (r_state == S_DATA) ? r_count + 1'b1 : '0;
         r_stop_idx <= (r_state == S_STOP) ? ~r_stop_idx : 1'b0;
         // LSB arrives first, so after DATA_BITS shifts bit i sits at index i
         if (w_shift_en) r_shift <= {in, r_shift[DATA_BITS-1:1]};
         if (w_par_ld)   r_par   <= in;
         r_done <= w_load;
         r_perr <= w_commit && !w_par_ok;
         r_ferr <= w_stop_bad;
         r_ovr  <= w_commit && w_par_ok && r_out_valid && !out_ready;
         if (w_load) begin
            r_out_data  <= r_shift;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign done       = r_done;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign overrun    = r_ovr;

endmodule
